flash_audio_player: RTL and testbench

Consumer stage directly downstream of the flash read handshake block: issues word-read requests (23-bit address) to it, captures each returned 32-bit word, and plays it as two 16-bit audio samples paced by an external sample-rate strobe. It supports play/pause, forward/reverse direction and restart, with address wrap-around between configurable start and end word addresses. Its registered sample output feeds the audio codec interface.

---
 rtl/flash_audio_player.sv | 90 +++++++++
 tb/tb_flash_audio_player.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_audio_player.sv
// flash_audio_player: fetches 32-bit words from the flash read block and plays them as paced 16-bit samples.
module flash_audio_player #(
  parameter logic [22:0] START_ADDR = 23'h000000,
  parameter logic [22:0] END_ADDR = 23'h07FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic        play,
  input  logic        direction,
  input  logic        restart,
  output logic        start_read,
  output logic [22:0] request_addr,
  input  logic        done,
  input  logic [31:0] data_in,
  output logic [15:0] audio_out,
  output logic        sample_strobe,
  output logic        underrun
);
  typedef enum logic [2:0] {IDLE, REQUEST, WAIT_DONE, WAIT_RELEASE, PLAY_FIRST, PLAY_SECOND} state_t;
  state_t state, state_n;
  logic [22:0] addr, addr_n, step_addr, restart_addr, request_addr_n;
  logic [31:0] word, word_n;
  logic [15:0] audio_n;
  logic dir, dir_n, pend, pend_n, rpend, rpend_n, underrun_n;
  logic fetching, playing, consume, restart_now, release_restart, apply_restart, advance;
  assign fetching = state == REQUEST || state == WAIT_DONE || state == WAIT_RELEASE;
  assign playing = state == PLAY_FIRST || state == PLAY_SECOND;
  assign consume = playing && play && (sample_tick || pend) && !restart;
  assign restart_now = restart && !fetching;
  // a restart seen during a fetch is deferred until the flash block has released done
  assign release_restart = state == WAIT_RELEASE && !done && (rpend || restart);
  assign apply_restart = restart_now || release_restart;
  assign advance = consume && state == PLAY_SECOND;
  assign restart_addr = direction ? END_ADDR : START_ADDR;
  assign step_addr = direction ? (addr == START_ADDR ? END_ADDR : addr - 23'd1)
                               : (addr == END_ADDR ? START_ADDR : addr + 23'd1);
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:         state_n = play && !done ? REQUEST : IDLE;
      REQUEST:      state_n = WAIT_DONE;
      WAIT_DONE:    state_n = done ? WAIT_RELEASE : WAIT_DONE;
      WAIT_RELEASE: state_n = done ? WAIT_RELEASE : release_restart ? REQUEST : PLAY_FIRST;
      PLAY_FIRST:   state_n = consume ? PLAY_SECOND : PLAY_FIRST;
      PLAY_SECOND:  state_n = consume ? REQUEST : PLAY_SECOND;
      default:      state_n = IDLE;
    endcase
    if (restart_now) state_n = play && !done ? REQUEST : IDLE;
  end
  always_comb begin
    addr_n = apply_restart ? restart_addr : advance ? step_addr : addr;
    dir_n = apply_restart || advance ? direction : dir;
    pend_n = apply_restart ? 1'b0 : consume ? pend && sample_tick : fetching && sample_tick ? 1'b1 : pend;
    rpend_n = release_restart ? 1'b0 : fetching && restart ? 1'b1 : rpend;
    underrun_n = underrun || (fetching && sample_tick && pend);
    word_n = state == WAIT_DONE && done ? data_in : word;
    audio_n = !consume ? audio_out : (state == PLAY_FIRST) != dir ? word[15:0] : word[31:16];
    request_addr_n = state_n == REQUEST ? addr_n : request_addr;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= START_ADDR;
      word <= '0;
      dir <= 1'b0;
      pend <= 1'b0;
      rpend <= 1'b0;
      underrun <= 1'b0;
      audio_out <= '0;
      sample_strobe <= 1'b0;
      start_read <= 1'b0;
      request_addr <= START_ADDR;
    end else begin
      addr <= addr_n;
      word <= word_n;
      dir <= dir_n;
      pend <= pend_n;
      rpend <= rpend_n;
      underrun <= underrun_n;
      audio_out <= audio_n;
      sample_strobe <= consume;
      start_read <= state_n == REQUEST;
      request_addr <= request_addr_n;
    end
  end
endmodule

// File: tb/tb_flash_audio_player.sv
// tb_flash_audio_player: flash model plus request/sample scoreboard around flash_audio_player.
module tb_flash_audio_player;
  logic clk = 0, reset = 1, sample_tick = 0, play = 0, direction = 0, restart = 0, done = 0;
  logic [31:0] data_in = '0;
  logic start_read, sample_strobe, underrun;
  logic [22:0] request_addr;
  logic [15:0] audio_out;

  flash_audio_player dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .play(play), .direction(direction),
    .restart(restart), .start_read(start_read), .request_addr(request_addr), .done(done),
    .data_in(data_in), .audio_out(audio_out), .sample_strobe(sample_strobe), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [22:0] addr; logic [15:0] first; logic [15:0] second; } vec_t;
  vec_t fwd [3];
  logic [15:0] exp_aud [$];
  logic [22:0] exp_req [$];
  int checks = 0, errors = 0, nstrobe = 0, snap = 0;
  int flash_lat = 1, flash_hold = 2, fl_cnt = 0;
  logic fl_busy = 0;
  logic [22:0] fl_addr = '0;

  function automatic logic [31:0] flash_word(input logic [22:0] a);
    case (a)
      23'h000000: return 32'hAAAA5555;
      23'h000001: return 32'h12345678;
      23'h000002: return 32'hCAFEBABE;
      23'h07FFFF: return 32'h0F0F1E1E;
      23'h07FFFE: return 32'h22223333;
      default:    return {16'hBEEF, a[15:0]};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // one negedge: score DUT outputs, then advance the flash model
  task automatic step();
    logic [15:0] ea;
    logic [22:0] er;
    @(negedge clk);
    if (sample_strobe) begin
      nstrobe++;
      if (exp_aud.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected got audio_out=%h expected no strobe", audio_out);
      end else begin
        ea = exp_aud.pop_front();
        chk("audio_sample", 32'(audio_out), 32'(ea));
      end
    end
    if (start_read) begin
      if (exp_req.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL start_read_unexpected got request_addr=%h expected no request", request_addr);
      end else begin
        er = exp_req.pop_front();
        chk("request_addr", 32'(request_addr), 32'(er));
      end
      chk("start_read_while_busy", 32'(fl_busy), 0);
      fl_busy = 1;
      fl_cnt = flash_lat;
      fl_addr = request_addr;
    end else if (fl_busy && !done) begin
      if (fl_cnt > 1) fl_cnt--;
      else begin
        done = 1;
        data_in = flash_word(fl_addr);
        fl_cnt = flash_hold;
      end
    end else if (done) begin
      if (fl_cnt > 1) fl_cnt--;
      else begin
        done = 0;
        fl_busy = 0;
      end
    end
  endtask

  task automatic tick();
    sample_tick = 1;
    step();
    sample_tick = 0;
    repeat (12) step();
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_req.size() != 0 || exp_aud.size() != 0) && k < budget) begin
      step();
      k++;
    end
    chk("drain_req_left", 32'(exp_req.size()), 0);
    chk("drain_aud_left", 32'(exp_aud.size()), 0);
    exp_req.delete();
    exp_aud.delete();
  endtask

  initial begin
    fwd[0] = '{23'h000000, 16'h5555, 16'hAAAA};
    fwd[1] = '{23'h000001, 16'h5678, 16'h1234};
    fwd[2] = '{23'h000002, 16'hBABE, 16'hCAFE};
    repeat (3) step();
    reset = 0;
    step();
    chk("rst_start_read", 32'(start_read), 0);
    chk("rst_request_addr", 32'(request_addr), 0);
    chk("rst_audio_out", 32'(audio_out), 0);
    chk("rst_sample_strobe", 32'(sample_strobe), 0);
    chk("rst_underrun", 32'(underrun), 0);
    repeat (5) step();

    // forward play from the table
    for (int i = 0; i < 3; i++) exp_req.push_back(fwd[i].addr);
    exp_req.push_back(23'h000003);
    play = 1;
    repeat (10) step();
    for (int i = 0; i < 3; i++) begin
      exp_aud.push_back(fwd[i].first);
      exp_aud.push_back(fwd[i].second);
      tick();
      tick();
      chk("fwd_second", 32'(audio_out), 32'(fwd[i].second));
    end
    drain(50);
    chk("fwd_strobes", 32'(nstrobe), 6);

    // pause in PLAY_SECOND
    exp_aud.push_back(16'h0003);
    tick();
    snap = nstrobe;
    play = 0;
    repeat (5) tick();
    chk("pause_audio_hold", 32'(audio_out), 32'h0003);
    chk("pause_no_strobe", 32'(nstrobe), 32'(snap));
    play = 1;
    exp_aud.push_back(16'hBEEF);
    exp_req.push_back(23'h000004);
    tick();
    chk("resume_second", 32'(audio_out), 32'hBEEF);
    drain(30);

    // reverse restart and reverse stepping
    direction = 1;
    exp_req.push_back(23'h07FFFF);
    restart = 1;
    step();
    restart = 0;
    repeat (10) step();
    exp_aud.push_back(16'h0F0F);
    exp_aud.push_back(16'h1E1E);
    exp_req.push_back(23'h07FFFE);
    tick();
    tick();
    chk("rev_second", 32'(audio_out), 32'h1E1E);
    exp_aud.push_back(16'h2222);
    exp_aud.push_back(16'h3333);
    exp_req.push_back(23'h07FFFD);
    tick();
    tick();
    chk("rev_second_2", 32'(audio_out), 32'h3333);
    drain(30);

    // reverse wrap from START_ADDR; direction change mid-word keeps half order
    direction = 0;
    exp_req.push_back(23'h000000);
    restart = 1;
    step();
    restart = 0;
    repeat (10) step();
    exp_aud.push_back(16'h5555);
    tick();
    direction = 1;
    exp_aud.push_back(16'hAAAA);
    exp_req.push_back(23'h07FFFF);
    tick();
    chk("midword_dir_second", 32'(audio_out), 32'hAAAA);
    exp_aud.push_back(16'h0F0F);
    tick();
    chk("rev_wrap_first", 32'(audio_out), 32'h0F0F);

    // forward wrap from END_ADDR
    direction = 0;
    exp_aud.push_back(16'h1E1E);
    exp_req.push_back(23'h000000);
    tick();
    chk("fwd_wrap_second", 32'(audio_out), 32'h1E1E);
    drain(30);

    // restart during WAIT_DONE: word at addr 1 must never play
    flash_lat = 6;
    flash_hold = 3;
    exp_aud.push_back(16'h5555);
    tick();
    exp_aud.push_back(16'hAAAA);
    exp_req.push_back(23'h000001);
    exp_req.push_back(23'h000000);
    sample_tick = 1;
    step();
    sample_tick = 0;
    step();
    restart = 1;
    step();
    restart = 0;
    drain(60);
    chk("restart_req_addr", 32'(request_addr), 0);
    repeat (15) step();
    exp_aud.push_back(16'h5555);
    tick();
    chk("restart_first", 32'(audio_out), 32'h5555);

    // underrun: fetch spans three tick periods
    flash_lat = 50;
    flash_hold = 2;
    exp_aud.push_back(16'hAAAA);
    exp_req.push_back(23'h000001);
    exp_aud.push_back(16'h5678);
    repeat (4) tick();
    chk("underrun_set", 32'(underrun), 1);
    drain(100);
    chk("pending_consumed_once", 32'(audio_out), 32'h5678);
    flash_lat = 1;
    repeat (5) step();
    exp_aud.push_back(16'h1234);
    exp_req.push_back(23'h000002);
    tick();
    chk("after_underrun_second", 32'(audio_out), 32'h1234);
    chk("underrun_sticky", 32'(underrun), 1);
    drain(30);

    // reset mid-fetch with done held high afterwards
    flash_hold = 20;
    exp_aud.push_back(16'hBABE);
    tick();
    exp_aud.push_back(16'hCAFE);
    exp_req.push_back(23'h000003);
    sample_tick = 1;
    step();
    sample_tick = 0;
    repeat (3) step();
    reset = 1;
    repeat (2) step();
    reset = 0;
    flash_hold = 2;
    step();
    chk("midreset_audio", 32'(audio_out), 0);
    chk("midreset_underrun", 32'(underrun), 0);
    chk("midreset_start_read", 32'(start_read), 0);
    chk("midreset_done_stale", 32'(done), 1);
    exp_req.push_back(23'h000000);
    drain(80);
    chk("midreset_req_addr", 32'(request_addr), 0);
    repeat (15) step();
    exp_aud.push_back(16'h5555);
    tick();
    chk("midreset_first", 32'(audio_out), 32'h5555);
    drain(30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
